// File: rtl/game_scoreboard.sv
// ---------------------------------------------------------------------------
// game_scoreboard
//
// Match-level scoreboard that sits behind the round engine. Each rising
// edge of winner_clk is one round. The block counts rounds and round wins
// per player, and declares a champion when a player reaches WIN_ROUNDS
// wins or when MAX_ROUNDS rounds have been played.
//
// Optional build macro:
//   SCOREBOARD_SYNC_EN - winner_clk passes through a 2-flop synchronizer
//                        and Result through two matching delay flops
//                        before edge detection. Round latency grows by 2.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   Reset       in   1      asynchronous active-low reset
//   winner_clk  in   1      round-done strobe; each 0->1 is one round
//   Result      in   2      00 none, 01 player 1, 10 player 2, 11 draw
//   Start       in   1      start a match from IDLE
//   Clear       in   1      return to IDLE from any state, zero outputs
//   Score1      out  CNT_W  round wins, player 1
//   Score2      out  CNT_W  round wins, player 2
//   Round_cnt   out  CNT_W  rounds played in the current match
//   Match_over  out  1      high while in DONE
//   Champion    out  2      00 none, 01 player 1, 10 player 2, 11 tie
//   Champ_pulse out  1      one-cycle pulse on entry to DONE
// ---------------------------------------------------------------------------
module game_scoreboard #(
  parameter int WIN_ROUNDS = 3,
  parameter int MAX_ROUNDS = 5,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             winner_clk,
  input  logic [1:0]       Result,
  input  logic             Start,
  input  logic             Clear,
  output logic [CNT_W-1:0] Score1,
  output logic [CNT_W-1:0] Score2,
  output logic [CNT_W-1:0] Round_cnt,
  output logic             Match_over,
  output logic [1:0]       Champion,
  output logic             Champ_pulse
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [CNT_W-1:0] r_score1;
  logic [CNT_W-1:0] r_score2;
  logic [CNT_W-1:0] r_round;
  logic [1:0]       r_champion;
  logic             r_champ_pulse;

  logic             w_strobe;
  logic [1:0]       w_result;
  logic             w_q;
  logic             w_round_ev;
  logic [CNT_W-1:0] w_score1_upd;
  logic [CNT_W-1:0] w_score2_upd;
  logic [CNT_W-1:0] w_round_upd;
  logic             w_terminal;
  logic [1:0]       w_champ_calc;

  // -------------------------------------------------------------------------
  // Strobe input path
  // -------------------------------------------------------------------------
`ifdef SCOREBOARD_SYNC_EN
  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_res_d1;
  logic [1:0] r_res_d2;

  // Result is delayed by the same two stages so it stays aligned with the
  // synchronized strobe edge.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_res_d1 <= 2'b00;
      r_res_d2 <= 2'b00;
    end else begin
      r_sync1  <= winner_clk;
      r_sync2  <= r_sync1;
      r_res_d1 <= Result;
      r_res_d2 <= r_res_d1;
    end
  end

  assign w_strobe = r_sync2;
  assign w_result = r_res_d2;
`else
  assign w_strobe = winner_clk;
  assign w_result = Result;
`endif

  // Previous-strobe flop. Updates in every state so a strobe that is held
  // high (or that rises while IDLE/DONE) never produces a second event.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      w_q <= 1'b0;
    end else begin
      w_q <= w_strobe;
    end
  end

  assign w_round_ev = w_strobe & ~w_q;

  // Candidate counter values for this round; termination and champion are
  // judged on these so the deciding round is included.
  assign w_score1_upd = (w_result == 2'b01) ? r_score1 + CNT_W'(1) : r_score1;
  assign w_score2_upd = (w_result == 2'b10) ? r_score2 + CNT_W'(1) : r_score2;
  assign w_round_upd  = r_round + CNT_W'(1);

  assign w_terminal = (w_score1_upd == CNT_W'(WIN_ROUNDS)) ||
                      (w_score2_upd == CNT_W'(WIN_ROUNDS)) ||
                      (w_round_upd  == CNT_W'(MAX_ROUNDS));

  assign w_champ_calc = (w_score1_upd > w_score2_upd) ? 2'b01 :
                        (w_score2_upd > w_score1_upd) ? 2'b10 : 2'b11;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state (Clear outranks Start)
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (Clear) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (Start) w_state_next = S_PLAY;
        S_PLAY:  if (w_round_ev && w_terminal) w_state_next = S_DONE;
        S_DONE:  w_state_next = S_DONE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    Match_over  = (r_state == S_DONE);
    Score1      = r_score1;
    Score2      = r_score2;
    Round_cnt   = r_round;
    Champion    = r_champion;
    Champ_pulse = r_champ_pulse;
  end

  // -------------------------------------------------------------------------
  // Counters and champion
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_score1      <= '0;
      r_score2      <= '0;
      r_round       <= '0;
      r_champion    <= 2'b00;
      r_champ_pulse <= 1'b0;
    end else begin
      r_champ_pulse <= 1'b0;
      if (Clear) begin
        r_score1   <= '0;
        r_score2   <= '0;
        r_round    <= '0;
        r_champion <= 2'b00;
      end else begin
        case (r_state)
          S_IDLE: begin
            // A round edge coincident with Start is deliberately dropped.
            if (Start) begin
              r_score1   <= '0;
              r_score2   <= '0;
              r_round    <= '0;
              r_champion <= 2'b00;
            end
          end
          S_PLAY: begin
            if (w_round_ev) begin
              r_score1 <= w_score1_upd;
              r_score2 <= w_score2_upd;
              r_round  <= w_round_upd;
              if (w_terminal) begin
                r_champion    <= w_champ_calc;
                r_champ_pulse <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_game_scoreboard
//
// Directed, table-driven bench for game_scoreboard with default parameters
// and SCOREBOARD_SYNC_EN undefined. Each table record is one operation
// (round, Start, Clear, Start+Clear) plus the outputs expected one clock
// edge later. Hand-written sequences cover the held-high strobe and the
// asynchronous mid-match reset.
// ---------------------------------------------------------------------------
module tb_game_scoreboard;

  localparam int CNT_W = 4;

  localparam logic [1:0] OP_ROUND = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_BOTH  = 2'd3;

  typedef struct {
    logic [1:0]       op;
    logic [1:0]       res;
    logic [CNT_W-1:0] s1;
    logic [CNT_W-1:0] s2;
    logic [CNT_W-1:0] rc;
    logic             mo;
    logic [1:0]       ch;
    logic             cp;
  } vec_t;

  logic             clk;
  logic             Reset;
  logic             winner_clk;
  logic [1:0]       Result;
  logic             Start;
  logic             Clear;
  logic [CNT_W-1:0] Score1;
  logic [CNT_W-1:0] Score2;
  logic [CNT_W-1:0] Round_cnt;
  logic             Match_over;
  logic [1:0]       Champion;
  logic             Champ_pulse;

  int   n_cmp;
  int   n_err;
  vec_t vecs[$];

  game_scoreboard #(
    .WIN_ROUNDS (3),
    .MAX_ROUNDS (5),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .winner_clk  (winner_clk),
    .Result      (Result),
    .Start       (Start),
    .Clear       (Clear),
    .Score1      (Score1),
    .Score2      (Score2),
    .Round_cnt   (Round_cnt),
    .Match_over  (Match_over),
    .Champion    (Champion),
    .Champ_pulse (Champ_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [1:0] op, input logic [1:0] res,
                     input int s1, input int s2, input int rc,
                     input logic mo, input logic [1:0] ch, input logic cp);
    vec_t v;
    v.op = op;  v.res = res;
    v.s1 = CNT_W'(s1); v.s2 = CNT_W'(s2); v.rc = CNT_W'(rc);
    v.mo = mo;  v.ch = ch;  v.cp = cp;
    vecs.push_back(v);
  endtask

  task automatic cmp1(input string tag, input string fld, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s %s: got %0d, want %0d", tag, fld, got, want);
    end
  endtask

  task automatic chk(input string tag, input logic [CNT_W-1:0] s1,
                     input logic [CNT_W-1:0] s2, input logic [CNT_W-1:0] rc,
                     input logic mo, input logic [1:0] ch, input logic cp);
    cmp1(tag, "Score1",      int'(Score1),      int'(s1));
    cmp1(tag, "Score2",      int'(Score2),      int'(s2));
    cmp1(tag, "Round_cnt",   int'(Round_cnt),   int'(rc));
    cmp1(tag, "Match_over",  int'(Match_over),  int'(mo));
    cmp1(tag, "Champion",    int'(Champion),    int'(ch));
    cmp1(tag, "Champ_pulse", int'(Champ_pulse), int'(cp));
    $display("%-14s S1=%0d S2=%0d RC=%0d MO=%0d CH=%b CP=%0d", tag,
             Score1, Score2, Round_cnt, Match_over, Champion, Champ_pulse);
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 of a later edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    case (v.op)
      OP_ROUND: begin winner_clk = 1'b1; Result = v.res; end
      OP_START: Start = 1'b1;
      OP_CLEAR: Clear = 1'b1;
      default:  begin Start = 1'b1; Clear = 1'b1; end
    endcase
    tick();
    chk(tag, v.s1, v.s2, v.rc, v.mo, v.ch, v.cp);
    winner_clk = 1'b0;
    Start      = 1'b0;
    Clear      = 1'b0;
    Result     = 2'b00;
    // Gap cycle: strobe low, and any champion pulse must already be gone.
    tick();
    cmp1({tag, "_gap"}, "Champ_pulse", int'(Champ_pulse), 0);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    Reset      = 1'b0;
    winner_clk = 1'b0;
    Result     = 2'b00;
    Start      = 1'b0;
    Clear      = 1'b0;

    //   op        res    s1 s2 rc mo ch     cp
    // Strobes before Start are ignored.
    add(OP_ROUND, 2'b01, 0, 0, 0, 0, 2'b00, 0);
    add(OP_ROUND, 2'b01, 0, 0, 0, 0, 2'b00, 0);
    // WIN_ROUNDS termination: 01,01,10,01.
    add(OP_START, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    add(OP_ROUND, 2'b01, 1, 0, 1, 0, 2'b00, 0);
    add(OP_ROUND, 2'b01, 2, 0, 2, 0, 2'b00, 0);
    add(OP_ROUND, 2'b10, 2, 1, 3, 0, 2'b00, 0);
    add(OP_ROUND, 2'b01, 3, 1, 4, 1, 2'b01, 1);
    // Strobes in DONE change nothing.
    add(OP_ROUND, 2'b10, 3, 1, 4, 1, 2'b01, 0);
    add(OP_ROUND, 2'b01, 3, 1, 4, 1, 2'b01, 0);
    add(OP_CLEAR, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    // MAX_ROUNDS termination: 11,00,10,01,10 -> player 2.
    add(OP_START, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    add(OP_ROUND, 2'b11, 0, 0, 1, 0, 2'b00, 0);
    add(OP_ROUND, 2'b00, 0, 0, 2, 0, 2'b00, 0);
    add(OP_ROUND, 2'b10, 0, 1, 3, 0, 2'b00, 0);
    add(OP_ROUND, 2'b01, 1, 1, 4, 0, 2'b00, 0);
    add(OP_ROUND, 2'b10, 1, 2, 5, 1, 2'b10, 1);
    // Start from DONE is not a restart; only Clear leaves DONE.
    add(OP_START, 2'b00, 1, 2, 5, 1, 2'b10, 0);
    add(OP_CLEAR, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    // Tie at MAX_ROUNDS: 01,10,11,01,10.
    add(OP_START, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    add(OP_ROUND, 2'b01, 1, 0, 1, 0, 2'b00, 0);
    add(OP_ROUND, 2'b10, 1, 1, 2, 0, 2'b00, 0);
    add(OP_ROUND, 2'b11, 1, 1, 3, 0, 2'b00, 0);
    add(OP_ROUND, 2'b01, 2, 1, 4, 0, 2'b00, 0);
    add(OP_ROUND, 2'b10, 2, 2, 5, 1, 2'b11, 1);
    // Start+Clear together: Clear wins, block lands in IDLE.
    add(OP_BOTH,  2'b00, 0, 0, 0, 0, 2'b00, 0);
    add(OP_ROUND, 2'b01, 0, 0, 0, 0, 2'b00, 0);
    // Start+Clear from IDLE also stays IDLE.
    add(OP_BOTH,  2'b00, 0, 0, 0, 0, 2'b00, 0);
    add(OP_ROUND, 2'b10, 0, 0, 0, 0, 2'b00, 0);

    // Reset state, checked while reset is still asserted.
    #12;
    chk("reset", 0, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    Reset = 1'b1;
    tick();

    foreach (vecs[i]) apply(vecs[i], i);

    // Strobe held high for 3 cycles counts once.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    winner_clk = 1'b1;
    Result     = 2'b01;
    tick();
    tick();
    tick();
    chk("held_high", 1, 0, 1, 0, 2'b00, 0);
    winner_clk = 1'b0;
    Result     = 2'b00;
    tick();
    chk("held_low", 1, 0, 1, 0, 2'b00, 0);
    winner_clk = 1'b1;
    Result     = 2'b10;
    tick();
    chk("second_rnd", 1, 1, 2, 0, 2'b00, 0);
    winner_clk = 1'b0;
    Result     = 2'b00;

    // Asynchronous reset mid-match, between clock edges.
    @(negedge clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_rst", 0, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    Reset = 1'b1;
    tick();
    chk("post_rst", 0, 0, 0, 0, 2'b00, 0);
    // After reset the block is IDLE: a strobe is ignored.
    winner_clk = 1'b1;
    Result     = 2'b01;
    tick();
    chk("rst_idle", 0, 0, 0, 0, 2'b00, 0);
    winner_clk = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_scoreboard.md
# game_scoreboard

Match-level scoreboard directly downstream of the `game` round engine. It consumes the per-round `Result` and the `winner_clk` round-done strobe, and accumulates per-player round wins and the round count. It declares a match champion when a player reaches `WIN_ROUNDS` wins or `MAX_ROUNDS` rounds have been played. Its outputs drive the board display and LEDs.

## Interface
Parameters:
- `WIN_ROUNDS`, default 3: round wins that end the match.
- `MAX_ROUNDS`, default 5: rounds after which the match ends regardless of score.
- `CNT_W`, default 4: counter width. Legal configurations satisfy `1 <= WIN_ROUNDS <= MAX_ROUNDS < 2^CNT_W`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock, rising edge.
- `Reset`  in  1: asynchronous, active-low reset.
- `winner_clk`  in  1: round-done strobe from `game`. Each 0->1 transition sampled on `clk` is one round.
- `Result`  in  2: round outcome. 00 = no winner, 01 = first player, 10 = second player, 11 = draw.
- `Start`  in  1: synchronous. Starts a match from IDLE.
- `Clear`  in  1: synchronous. Aborts or clears the match from any state and returns to IDLE.
- `Score1`, `Score2`  out  CNT_W each: round wins per player.
- `Round_cnt`  out  CNT_W: rounds played in the current match.
- `Match_over`  out  1: high while in DONE.
- `Champion`  out  2: 00 = none, 01 = first player, 10 = second player, 11 = tie.
- `Champ_pulse`  out  1: one-cycle pulse on entry to DONE.

## Operation
- States:
  - IDLE: reset state; round strobes are ignored.
  - PLAY: round strobes are counted.
  - DONE: results are frozen and strobes are ignored.
- Transitions:
  - IDLE->PLAY on `Start`. Counters and `Champion` are cleared on this transition.
  - PLAY->DONE on the terminating round.
  - Any state->IDLE on `Clear`, with all outputs zeroed.
  - `Clear` has priority over `Start`.
- Edge detect: one internal flop `w_q` holds the previous `winner_clk`. `round_ev = winner_clk & ~w_q`. `w_q` updates in every state, so a strobe held high counts as exactly one round.
- Per `round_ev` in PLAY:
  - `Round_cnt` += 1.
  - `Result` 01: `Score1` += 1.
  - `Result` 10: `Score2` += 1.
  - `Result` 00 or 11: no score change.
  - `Result` is sampled in the same cycle as the edge.
- Termination is evaluated on the updated values. If `Score1 == WIN_ROUNDS`, or `Score2 == WIN_ROUNDS`, or `Round_cnt == MAX_ROUNDS`, the block enters DONE.
- Champion selection: the higher score wins. Equal scores give 11. Both players cannot reach `WIN_ROUNDS` in the same round.
- Counters cannot exceed their limits because DONE blocks further updates, so no wrap-around occurs.
- A `round_ev` coincident with `Start` in IDLE is ignored.

## Timing
- Reset asserted: asynchronously forces IDLE and all outputs to 0 (`Score1`, `Score2`, `Round_cnt`, `Match_over`, `Champion`, `Champ_pulse`), and `w_q` to 0. This applies mid-match as well. Deassertion is sampled on the next `clk` edge.
- Latency:
  - A `winner_clk` rising level seen at clock edge k updates the counters, visible after edge k.
  - A terminating round sets `Match_over` and `Champion` after the same edge k.
  - `Champ_pulse` is high for the single cycle following edge k.
- `Start` or `Clear` takes effect at the next clock edge.
- Back-to-back strobes need `winner_clk` low for at least one sampled cycle between rounds.

## Configuration
- `SCOREBOARD_SYNC_EN` defined: `winner_clk` passes through a 2-flop synchronizer before edge detect. All round latency grows by 2 cycles. `Result` is delayed by matching pipeline flops so the two stay aligned.
- `SCOREBOARD_SYNC_EN` undefined: `winner_clk` goes directly into edge detect, with the latency stated above.

## Test plan
All scenarios use default parameters, with `Start` pulsed after reset unless stated.
- Reset, then strobe `winner_clk` with `Result`=01 before `Start` -> all outputs stay 0 and the state stays IDLE.
- `Start`; results 01,01,10,01 -> after the 4th round `Score1`=3, `Score2`=1, `Round_cnt`=4, `Match_over`=1, `Champion`=01, `Champ_pulse` high for exactly 1 cycle.
- Results 11,00,10,01,10 -> `Round_cnt`=5, `Score1`=1, `Score2`=2, `Champion`=10 (MAX_ROUNDS termination).
- Results 01,10,11,01,10 -> `Score1`=2, `Score2`=2, `Round_cnt`=5, `Champion`=11.
- `winner_clk` held high for 3 cycles -> `Round_cnt` += 1 only. Strobes in DONE -> no change. `Clear` -> IDLE, all outputs 0. `Start`+`Clear` together -> IDLE.
- After 2 rounds (01,10), assert `Reset` mid-cycle -> outputs 0 immediately, without waiting for `clk`. Repeat the 01,01,10,01 scenario with `SCOREBOARD_SYNC_EN` defined -> same final values, with each update 2 cycles later.
